// File: rtl/memory_access_hs.sv
// Memory-access stage with req/gnt/rvalid data bus, sub-word lanes and timeout.
// Optional MISALIGN_TRAP_EN: misaligned accesses skip the bus and flag REGMmisalign.
module memory_access_hs #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               MAREGclear,
  input  logic               MAREGstall,
  input  logic               REGAvalid,
  input  logic               REGAmemread,
  input  logic               REGAwenable,
  input  logic [2:0]         REGAllcntl,
  input  logic [2:0]         REGAslcntl,
  input  logic [WIDTH-1:0]   REGAaluresult,
  input  logic [WIDTH-1:0]   REGAreg2data,
  input  logic [4:0]         REGArd,
  input  logic               REGAregwrite,
  output logic               dmemreq,
  output logic               dmemwe,
  output logic [WIDTH-1:0]   dmemaddr,
  output logic [WIDTH-1:0]   dmemwdata,
  output logic [WIDTH/8-1:0] dmembe,
  input  logic               dmemgnt,
  input  logic               dmemrvalid,
  input  logic [WIDTH-1:0]   dmemrdata,
  output logic               memstall,
  output logic               REGMvalid,
  output logic [4:0]         REGMrd,
  output logic               REGMregwrite,
  output logic [WIDTH-1:0]   REGMaluresult,
  output logic [WIDTH-1:0]   REGMdmemdata,
  output logic               REGMbuserr,
  output logic               REGMmisalign
);

  localparam int NB   = WIDTH / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW   = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              orphan;
  logic [WIDTH-1:0]  res_data;
  logic              res_buserr;
  logic              res_mis;

  logic              memop;
  logic              is_st;
  logic              sgn;
  logic              trap;
  logic [1:0]        sz;
  logic [OFFW-1:0]   off;
  logic [OFFW-1:0]   szlow;
  logic [OFFW-1:0]   off_al;
  logic [7:0]        nbytes;
  logic [6:0]        nbits;
  logic [NB-1:0]     bemask;
  logic [WIDTH-1:0]  rep;
  logic [WIDTH-1:0]  sh;
  logic [WIDTH-1:0]  keep;
  logic [WIDTH-1:0]  top;
  logic              sbit;
  logic [WIDTH-1:0]  ext;
  logic              unused;

  assign unused = REGAslcntl[2];

  always_comb begin
    is_st = REGAwenable;
    memop = REGAvalid & (REGAmemread | REGAwenable);
    sz = is_st ? REGAslcntl[1:0] : REGAllcntl[1:0];
    if (WIDTH == 32 && sz == 2'd3) sz = 2'd2;
    sgn    = !is_st && !REGAllcntl[2];
    off    = REGAaluresult[OFFW-1:0];
    szlow  = OFFW'((4'd1 << sz) - 4'd1);
    off_al = off & ~szlow;
    nbytes = 8'd1 << sz;
    nbits  = 7'd8 << sz;
    bemask = NB'((16'd1 << nbytes) - 16'd1);
  end

`ifdef MISALIGN_TRAP_EN
  assign trap = memop & (|(off & szlow));
`else
  assign trap = 1'b0;
`endif

  // Replicate the store operand into every lane before shifting.
  always_comb begin
    unique case (sz)
      2'd0:    rep = {NB{REGAreg2data[7:0]}};
      2'd1:    rep = {(NB/2){REGAreg2data[15:0]}};
      2'd2:    rep = {(NB/4){REGAreg2data[31:0]}};
      default: rep = REGAreg2data;
    endcase
  end

  always_comb begin
    sh   = dmemrdata >> {off_al, 3'b000};
    keep = ~({WIDTH{1'b1}} << nbits);
    top  = {{(WIDTH-1){1'b0}}, 1'b1} << (nbits - 7'd1);
    sbit = sgn & (|(sh & top));
    ext  = (sh & keep) | ({WIDTH{sbit}} & ~keep);
  end

  assign dmemreq   = (state == S_REQ);
  assign dmemwe    = (state == S_REQ) & REGAwenable;
  assign dmemaddr  = {REGAaluresult[WIDTH-1:OFFW], {OFFW{1'b0}}};
  assign dmembe    = bemask << off_al;
  assign dmemwdata = rep << {off_al, 3'b000};
  assign memstall  = memop & (state != S_DONE);

  always_ff @(posedge clk) begin
    if (MAREGclear) begin
      state         <= S_IDLE;
      cnt           <= '0;
      orphan        <= (state == S_WAIT) |
                       ((state == S_REQ) & !is_st & dmemgnt);
      res_data      <= '0;
      res_buserr    <= 1'b0;
      res_mis       <= 1'b0;
      REGMvalid     <= 1'b0;
      REGMrd        <= '0;
      REGMregwrite  <= 1'b0;
      REGMaluresult <= '0;
      REGMdmemdata  <= '0;
      REGMbuserr    <= 1'b0;
      REGMmisalign  <= 1'b0;
    end else begin
      // A flushed load's response may still be in flight.
      if (orphan && state != S_WAIT) begin
        if (dmemrvalid || cnt == TMAX) begin
          orphan <= 1'b0;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      unique case (state)
        S_IDLE: begin
          if (memop) begin
            if (trap) begin
              res_data   <= '0;
              res_buserr <= 1'b0;
              res_mis    <= 1'b1;
              state      <= S_DONE;
            end else begin
              res_mis <= 1'b0;
              state   <= S_REQ;
            end
          end else if (!MAREGstall) begin
            REGMvalid     <= REGAvalid;
            REGMrd        <= REGArd;
            REGMregwrite  <= REGAregwrite;
            REGMaluresult <= REGAaluresult;
            REGMdmemdata  <= '0;
            REGMbuserr    <= 1'b0;
            REGMmisalign  <= 1'b0;
          end
        end
        S_REQ: begin
          if (dmemgnt) begin
            res_data   <= '0;
            res_buserr <= 1'b0;
            if (is_st) begin
              state <= S_DONE;
            end else begin
              state <= S_WAIT;
              cnt   <= '0;
            end
          end
        end
        S_WAIT: begin
          if (dmemrvalid && !orphan) begin
            res_data <= ext;
            cnt      <= '0;
            state    <= S_DONE;
          end else if (cnt == TMAX) begin
            res_data   <= '0;
            res_buserr <= 1'b1;
            orphan     <= 1'b0;
            cnt        <= '0;
            state      <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
            if (dmemrvalid) orphan <= 1'b0;
          end
        end
        S_DONE: begin
          if (!MAREGstall) begin
            REGMvalid     <= REGAvalid;
            REGMrd        <= REGArd;
            REGMregwrite  <= REGAregwrite & !res_mis;
            REGMaluresult <= REGAaluresult;
            REGMdmemdata  <= res_data;
            REGMbuserr    <= res_buserr;
            REGMmisalign  <= res_mis;
            state         <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_hs.sv
// Directed bench for memory_access_hs (WIDTH=32, TIMEOUT=16).
// Covers MISALIGN_TRAP_EN in both builds.
module tb_memory_access_hs;

  logic        clk = 1'b0;
  logic        MAREGclear, MAREGstall;
  logic        REGAvalid, REGAmemread, REGAwenable;
  logic [2:0]  REGAllcntl, REGAslcntl;
  logic [31:0] REGAaluresult, REGAreg2data;
  logic [4:0]  REGArd;
  logic        REGAregwrite;
  logic        dmemreq, dmemwe;
  logic [31:0] dmemaddr, dmemwdata;
  logic [3:0]  dmembe;
  logic        dmemgnt, dmemrvalid;
  logic [31:0] dmemrdata;
  logic        memstall;
  logic        REGMvalid;
  logic [4:0]  REGMrd;
  logic        REGMregwrite;
  logic [31:0] REGMaluresult, REGMdmemdata;
  logic        REGMbuserr, REGMmisalign;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  memory_access_hs #(.WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .MAREGclear(MAREGclear), .MAREGstall(MAREGstall),
    .REGAvalid(REGAvalid), .REGAmemread(REGAmemread),
    .REGAwenable(REGAwenable), .REGAllcntl(REGAllcntl),
    .REGAslcntl(REGAslcntl), .REGAaluresult(REGAaluresult),
    .REGAreg2data(REGAreg2data), .REGArd(REGArd),
    .REGAregwrite(REGAregwrite), .dmemreq(dmemreq), .dmemwe(dmemwe),
    .dmemaddr(dmemaddr), .dmemwdata(dmemwdata), .dmembe(dmembe),
    .dmemgnt(dmemgnt), .dmemrvalid(dmemrvalid), .dmemrdata(dmemrdata),
    .memstall(memstall), .REGMvalid(REGMvalid), .REGMrd(REGMrd),
    .REGMregwrite(REGMregwrite), .REGMaluresult(REGMaluresult),
    .REGMdmemdata(REGMdmemdata), .REGMbuserr(REGMbuserr),
    .REGMmisalign(REGMmisalign)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    REGAvalid = 1'b0;
    REGAmemread = 1'b0;
    REGAwenable = 1'b0;
    step();
  endtask

  task automatic store_op(input string tag, input logic [2:0] ctl,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] be, input logic [31:0] wd,
                          input int hold);
    REGAvalid = 1'b1; REGAwenable = 1'b1; REGAmemread = 1'b0;
    REGAslcntl = ctl; REGAaluresult = addr; REGAreg2data = data;
    REGArd = 5'd0; REGAregwrite = 1'b0;
    #1;
    chk({tag, "_idle_stall"}, 32'(memstall), 32'd1);
    chk({tag, "_idle_req"}, 32'(dmemreq), 32'd0);
    step();
    dmemgnt = 1'b1;
    #1;
    chk({tag, "_req"}, 32'(dmemreq), 32'd1);
    chk({tag, "_we"}, 32'(dmemwe), 32'd1);
    chk({tag, "_be"}, 32'(dmembe), be);
    chk({tag, "_wdata"}, dmemwdata, wd);
    chk({tag, "_addr"}, dmemaddr, addr & 32'hFFFF_FFFC);
    chk({tag, "_req_stall"}, 32'(memstall), 32'd1);
    step();
    dmemgnt = 1'b0;
    chk({tag, "_done_stall"}, 32'(memstall), 32'd0);
    chk({tag, "_done_valid"}, 32'(REGMvalid), 32'd0);
    MAREGstall = 1'b1;
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hold_valid"}, 32'(REGMvalid), 32'd0);
      chk({tag, "_hold_req"}, 32'(dmemreq), 32'd0);
    end
    MAREGstall = 1'b0;
    step();
    chk({tag, "_valid"}, 32'(REGMvalid), 32'd1);
    chk({tag, "_alu"}, REGMaluresult, addr);
    chk({tag, "_buserr"}, 32'(REGMbuserr), 32'd0);
    bubble();
  endtask

  task automatic load_op(input string tag, input logic [2:0] ctl,
                         input logic [31:0] addr, input logic [31:0] rdata,
                         input int lat, input logic [31:0] exp);
    REGAvalid = 1'b1; REGAmemread = 1'b1; REGAwenable = 1'b0;
    REGAllcntl = ctl; REGAaluresult = addr;
    REGArd = 5'd9; REGAregwrite = 1'b1;
    #1;
    chk({tag, "_idle_stall"}, 32'(memstall), 32'd1);
    step();
    dmemgnt = 1'b1;
    #1;
    chk({tag, "_req"}, 32'(dmemreq), 32'd1);
    chk({tag, "_we"}, 32'(dmemwe), 32'd0);
    step();
    dmemgnt = 1'b0;
    for (int i = 0; i < lat; i++) step();
    dmemrvalid = 1'b1;
    dmemrdata = rdata;
    step();
    dmemrvalid = 1'b0;
    dmemrdata = 32'h0;
    chk({tag, "_done_stall"}, 32'(memstall), 32'd0);
    chk({tag, "_done_valid"}, 32'(REGMvalid), 32'd0);
    step();
    chk({tag, "_data"}, REGMdmemdata, exp);
    chk({tag, "_valid"}, 32'(REGMvalid), 32'd1);
    chk({tag, "_rd"}, 32'(REGMrd), 32'd9);
    chk({tag, "_rw"}, 32'(REGMregwrite), 32'd1);
    chk({tag, "_buserr"}, 32'(REGMbuserr), 32'd0);
    chk({tag, "_mis"}, 32'(REGMmisalign), 32'd0);
    bubble();
  endtask

  initial begin
    MAREGclear = 1'b1; MAREGstall = 1'b0;
    REGAvalid = 1'b0; REGAmemread = 1'b0; REGAwenable = 1'b0;
    REGAllcntl = 3'd0; REGAslcntl = 3'd0;
    REGAaluresult = 32'h0; REGAreg2data = 32'h0;
    REGArd = 5'd0; REGAregwrite = 1'b0;
    dmemgnt = 1'b0; dmemrvalid = 1'b0; dmemrdata = 32'h0;
    step();
    step();
    chk("rst_valid", 32'(REGMvalid), 32'd0);
    chk("rst_data", REGMdmemdata, 32'd0);
    chk("rst_req", 32'(dmemreq), 32'd0);
    chk("rst_stall", 32'(memstall), 32'd0);
    MAREGclear = 1'b0;

    // Non-memory pass-through and stall hold
    REGAvalid = 1'b1; REGAaluresult = 32'h55; REGArd = 5'd3;
    REGAregwrite = 1'b1;
    #1 chk("pt_stall", 32'(memstall), 32'd0);
    step();
    chk("pt_alu", REGMaluresult, 32'h55);
    chk("pt_rd", 32'(REGMrd), 32'd3);
    chk("pt_valid", 32'(REGMvalid), 32'd1);
    MAREGstall = 1'b1; REGAaluresult = 32'h66;
    step();
    chk("pt_hold", REGMaluresult, 32'h55);
    MAREGstall = 1'b0;
    step();
    chk("pt_next", REGMaluresult, 32'h66);
    MAREGclear = 1'b1; MAREGstall = 1'b1;
    step();
    chk("clr_wins", 32'(REGMvalid), 32'd0);
    chk("clr_alu", REGMaluresult, 32'h0);
    MAREGclear = 1'b0; MAREGstall = 1'b0;
    bubble();

    store_op("sw", 3'b010, 32'h100, 32'hDEADBEEF, 32'hF, 32'hDEADBEEF, 0);
    store_op("sh", 3'b001, 32'h102, 32'h1234, 32'hC, 32'h12340000, 0);
    store_op("sb", 3'b000, 32'h101, 32'hA5, 32'h2, 32'hA5A5A500, 2);

    load_op("lb", 3'b000, 32'h103, 32'h80FFFFFF, 2, 32'hFFFFFF80);
    load_op("lbu", 3'b100, 32'h103, 32'h80FFFFFF, 2, 32'h00000080);
    load_op("lhu", 3'b101, 32'h102, 32'hABCD0000, 0, 32'h0000ABCD);
    load_op("lh", 3'b001, 32'h102, 32'hABCD0000, 1, 32'hFFFFABCD);
    load_op("lw", 3'b010, 32'h104, 32'h87654321, 0, 32'h87654321);

    // Response timeout
    REGAvalid = 1'b1; REGAmemread = 1'b1; REGAllcntl = 3'b010;
    REGAaluresult = 32'h200; REGArd = 5'd4; REGAregwrite = 1'b1;
    step();
    dmemgnt = 1'b1;
    step();
    dmemgnt = 1'b0;
    for (int i = 0; i < 15; i++) step();
    chk("to_wait16_stall", 32'(memstall), 32'd1);
    step();
    chk("to_done_stall", 32'(memstall), 32'd0);
    step();
    chk("to_buserr", 32'(REGMbuserr), 32'd1);
    chk("to_data", REGMdmemdata, 32'h0);
    chk("to_rw", 32'(REGMregwrite), 32'd1);
    chk("to_valid", 32'(REGMvalid), 32'd1);
    bubble();
    chk("to_buserr_clr", 32'(REGMbuserr), 32'd0);

    // Flush in WAIT leaves an orphan response to discard
    REGAvalid = 1'b1; REGAmemread = 1'b1; REGAllcntl = 3'b010;
    REGAaluresult = 32'h300; REGArd = 5'd6; REGAregwrite = 1'b1;
    step();
    dmemgnt = 1'b1;
    step();
    dmemgnt = 1'b0;
    MAREGclear = 1'b1;
    REGAvalid = 1'b0; REGAmemread = 1'b0;
    step();
    MAREGclear = 1'b0;
    chk("orph_clr_valid", 32'(REGMvalid), 32'd0);
    chk("orph_clr_req", 32'(dmemreq), 32'd0);
    REGAvalid = 1'b1; REGAmemread = 1'b1; REGAllcntl = 3'b010;
    REGAaluresult = 32'h304; REGArd = 5'd7;
    step();
    dmemgnt = 1'b1;
    #1 chk("orph_req", 32'(dmemreq), 32'd1);
    step();
    dmemgnt = 1'b0;
    dmemrvalid = 1'b1; dmemrdata = 32'h11111111;
    step();
    dmemrdata = 32'h22222222;
    chk("orph_discard_stall", 32'(memstall), 32'd1);
    step();
    dmemrvalid = 1'b0; dmemrdata = 32'h0;
    chk("orph_done_stall", 32'(memstall), 32'd0);
    step();
    chk("orph_data", REGMdmemdata, 32'h22222222);
    chk("orph_rd", 32'(REGMrd), 32'd7);
    bubble();

    // Misaligned word load
    REGAvalid = 1'b1; REGAmemread = 1'b1; REGAllcntl = 3'b010;
    REGAaluresult = 32'h101; REGArd = 5'd9; REGAregwrite = 1'b1;
`ifdef MISALIGN_TRAP_EN
    #1;
    chk("mis_idle_stall", 32'(memstall), 32'd1);
    chk("mis_idle_req", 32'(dmemreq), 32'd0);
    step();
    chk("mis_done_req", 32'(dmemreq), 32'd0);
    chk("mis_done_stall", 32'(memstall), 32'd0);
    step();
    chk("mis_flag", 32'(REGMmisalign), 32'd1);
    chk("mis_rw", 32'(REGMregwrite), 32'd0);
    chk("mis_data", REGMdmemdata, 32'h0);
    bubble();
`else
    #1;
    chk("mis_be", 32'(dmembe), 32'hF);
    chk("mis_addr", dmemaddr, 32'h100);
    load_op("mis_lw", 3'b010, 32'h101, 32'hCAFEF00D, 0, 32'hCAFEF00D);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_access_hs.md
Name: memory_access_hs

Overview:
- Next-generation memory-access pipeline stage. It replaces the fixed single-cycle data-memory assumption with a req/gnt/rvalid handshake.
- Adds sub-word load/store handling (byte enables, lane shift, sign/zero extension), a response timeout and a stall output to the hazard unit.
- Sits between the execute-stage register (REGA*) and the writeback-stage register (REGM*).
- Parametrised in datapath width (32/64).

Parameters:
- WIDTH, 32, datapath and memory bus width; legal values 32 or 64.
- TIMEOUT, 16, WAIT-state cycles without rvalid before a bus error is declared.

Ports:
- clk  in  1  clock
- MAREGclear  in  1  synchronous active-high reset/flush of stage state and REGM outputs
- MAREGstall  in  1  downstream stall; REGM registers hold
- REGAvalid  in  1  instruction in MA slot is valid
- REGAmemread  in  1  load request
- REGAwenable  in  1  store request
- REGAllcntl  in  3  load type: 000 LB, 001 LH, 010 LW, 011 LD (WIDTH=64 only), 100 LBU, 101 LHU, 110 LWU (WIDTH=64 only)
- REGAslcntl  in  3  store type: 000 SB, 001 SH, 010 SW, 011 SD (WIDTH=64 only)
- REGAaluresult  in  WIDTH  effective address / ALU result
- REGAreg2data  in  WIDTH  store data
- REGArd  in  5  destination register
- REGAregwrite  in  1  register write enable
- dmemreq  out  1  memory request
- dmemwe  out  1  1 = write
- dmemaddr  out  WIDTH  address aligned to bus word
- dmemwdata  out  WIDTH  lane-shifted store data
- dmembe  out  WIDTH/8  byte enables
- dmemgnt  in  1  request accepted
- dmemrvalid  in  1  read data valid
- dmemrdata  in  WIDTH  read data
- memstall  out  1  holds upstream stages
- REGMvalid  out  1  registered valid
- REGMrd  out  5  registered rd
- REGMregwrite  out  1  registered regwrite
- REGMaluresult  out  WIDTH  registered ALU result
- REGMdmemdata  out  WIDTH  registered extended load data
- REGMbuserr  out  1  timeout occurred on this instruction
- REGMmisalign  out  1  misaligned access (see Optional Feature)

Behaviour:
- Reset (MAREGclear=1 at clk edge): state=IDLE, timeout counter=0, orphan=0, all REGM* outputs 0. The dmem* outputs are combinational from the stage state and inputs, so dmemreq is 0 whenever state≠REQ.
- memop = REGAvalid & (REGAmemread | REGAwenable). REGAwenable has priority if both are set.
- States:
  - IDLE: on memop go to REQ. Without memop, the REGM registers load from REGA when !MAREGstall (one-cycle pass-through, no stall).
  - REQ: dmemreq=1, dmemwe=REGAwenable. Hold the request until dmemgnt. On gnt, a store goes to DONE and a load goes to WAIT with counter cleared.
  - WAIT: on dmemrvalid (and orphan=0), capture the extended data and go to DONE. If the counter reaches TIMEOUT-1 without rvalid, go to DONE with data=0 and buserr=1.
  - DONE: when !MAREGstall, the REGM registers load the result and state returns to IDLE. Otherwise hold DONE.
- memstall = memop & (state≠DONE).
- Minimum latency, counted from the IDLE cycle and with gnt/rvalid asserted as early as allowed:
  - store: REGM updated at end of cycle 2.
  - load: REGM updated at end of cycle 3.
- dmemaddr = REGAaluresult with its low log2(WIDTH/8) bits forced to 0. Byte offset = those low bits.
- dmembe: the access-size mask (1, 3, 0xF, 0xFF) shifted left by the offset.
- dmemwdata: store data replicated into lanes, shifted left by offset×8.
- Load: dmemrdata is shifted right by offset×8, truncated to the access size, then sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU) to WIDTH.
- rvalid outside WAIT is ignored. A gnt outside REQ is ignored.
- Clear mid-operation:
  - If MAREGclear occurs in WAIT, or in REQ on a load gnt cycle, set orphan=1.
  - While orphan=1, the next dmemrvalid is discarded and clears orphan. A later load's WAIT does not accept data until orphan=0.
  - The timeout counter applies while orphan=1 and clears orphan on expiry.
- Simultaneous MAREGclear and MAREGstall: clear wins.
- On a buserr, REGMregwrite is still passed through. The trap unit decides on it.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A memop whose offset is not a multiple of the access size goes IDLE→DONE without asserting dmemreq.
  - REGMmisalign=1, REGMregwrite=0, REGMdmemdata=0.
  - memstall stays high for that one IDLE cycle.
- Undefined:
  - Offset bits below the access size are ignored (the address is treated as naturally aligned).
  - REGMmisalign is tied to 0.

Test Plan:
- WIDTH=32, SW 0xDEADBEEF @0x100, gnt same cycle as req → dmembe=1111, dmemwdata=0xDEADBEEF, memstall high 2 cycles, REGMvalid=1 after cycle 2.
- LB @0x103, rdata=0x80FFFFFF, rvalid 3 cycles after gnt → REGMdmemdata=0xFFFFFF80. Same access with LBU → 0x00000080.
- SH 0x1234 @0x102 → dmembe=1100, dmemwdata=0x12340000. LHU @0x102, rdata=0xABCD0000 → 0x0000ABCD.
- Load with rvalid never asserted, TIMEOUT=16 → DONE after 16 WAIT cycles, REGMbuserr=1, REGMdmemdata=0, memstall drops.
- MAREGclear in WAIT, then a new LW; first rvalid (0x11111111) is discarded, second rvalid (0x22222222) is captured → REGMdmemdata=0x22222222.
- MISALIGN_TRAP_EN defined, LW @0x101 → dmemreq never asserted, REGMmisalign=1, REGMregwrite=0. Undefined → dmembe=1111, dmemaddr=0x100.
